// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device: inhibits the bus, issues
// request-to-send, shifts out 8 data bits + odd parity + stop on the
// device-generated clock, then checks the device ACK.
//
// Ports:
//   clk          system clock (rising edge)
//   reset        asynchronous active-low reset
//   tx_data      command byte, sampled when tx_start is accepted
//   tx_start     single-cycle request, accepted only when idle
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_clk_oe   1 pulls the PS/2 clock line low
//   ps2_data_oe  1 pulls the PS/2 data line low
//   busy         transfer in progress
//   done         one-cycle pulse: device ACKed and bus returned idle
//   ack_err      one-cycle pulse: device did not ACK
//   timeout_err  one-cycle pulse: no device clock edge for too long
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       idx, idx_next;
    logic [9:0]       frame, frame_next;
    logic             data_oe_q, data_oe_next;
    logic             done_next, ack_err_next, timeout_err_next;

    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fall;

    // Synchronizers reset to the idle-high bus level so no spurious
    // falling edge is seen when reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            frame       <= '0;
            data_oe_q   <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            frame       <= frame_next;
            data_oe_q   <= data_oe_next;
            done        <= done_next;
            ack_err     <= ack_err_next;
            timeout_err <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        idx_next         = idx;
        frame_next       = frame;
        data_oe_next     = data_oe_q;
        done_next        = 1'b0;
        ack_err_next     = 1'b0;
        timeout_err_next = 1'b0;
        ps2_clk_oe       = 1'b0;

        case (state)
            S_IDLE: begin
                data_oe_next = 1'b0;
                // The done pulse cycle already shows busy=0, but a request
                // arriving then is still dropped.
                if (tx_start && !done) begin
                    frame_next = {1'b1, ~^tx_data, tx_data};
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt == INHIBIT_LAST) begin
                    data_oe_next = 1'b1;    // start bit, visible during RTS
                    state_next   = S_RTS;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            S_RTS: begin
                ps2_clk_oe = 1'b1;
                cnt_next   = '0;
                state_next = S_SHIFT;
            end

            S_SHIFT: begin
                if (fall) begin
                    // frame is consumed from bit 0, so frame[0] is bit idx
                    data_oe_next = ~frame[0];
                    frame_next   = {1'b0, frame[9:1]};
                    cnt_next     = '0;
                    if (idx == 4'd9) begin
                        idx_next   = '0;
                        state_next = S_ACK;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    data_oe_next     = 1'b0;
                    timeout_err_next = 1'b1;
                    cnt_next         = '0;
                    state_next       = S_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            S_ACK: begin
                data_oe_next = 1'b0;
                if (fall) begin
                    cnt_next = '0;
                    if (data_s2) begin
                        ack_err_next = 1'b1;
                        state_next   = S_IDLE;
                    end else begin
                        state_next = S_WAIT_IDLE;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_err_next = 1'b1;
                    cnt_next         = '0;
                    state_next       = S_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            S_WAIT_IDLE: begin
                data_oe_next = 1'b0;
                if (clk_s2 && data_s2) begin
                    done_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else if (fall) begin
                    cnt_next = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_err_next = 1'b1;
                    cnt_next         = '0;
                    state_next       = S_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            default: begin
                data_oe_next = 1'b0;
                state_next   = S_IDLE;
            end
        endcase
    end

    assign ps2_data_oe = data_oe_q;
    assign busy        = (state != S_IDLE);

endmodule
